rf_read_arbiter: RTL and testbench
==================================

Name: rf_read_arbiter

Overview:
- Shares the single 32-entry register-file read port among NREQ requesters, e.g. decode rs, decode rt and the debug/monitor port.
- The read port is the 32-way, 32-bit combinational select mux.
- Each cycle the block picks one requester by round-robin and drives the mux select from that requester's address.
- It registers the selected word, applies $zero and write-bypass rules, and returns it one cycle later with a one-hot response strobe.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 5, register address width; the mux select is AW bits.
- DW, 32, data width.
- ZERO_R0, 1, when 1 a read of address 0 returns 0 regardless of mux data.
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, active-low.
- stall  in  1  pipeline stall; no new grants while high.
- req_valid  in  NREQ  per-requester read request.
- req_addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i]&req_ready[i].
- mux_select  out  AW  drives the select input of the register-file read mux.
- mux_data  in  DW  data_out of the read mux (combinational from mux_select).
- wr_en  in  1  register-file write strobe for the same cycle.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- resp_valid  out  NREQ  one-hot response strobe, one cycle.
- resp_data  out  DW  read data, valid when any resp_valid bit is 1.
- busy  out  1  any req_valid pending and not granted this cycle.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values, immediate on rst_n low:
  - resp_valid = 0, resp_data = 0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has top priority first.
  - req_ready = 0 while rst_n is low.
- Arbitration, combinational within the cycle:
  - Search order is last_grant+1, last_grant+2, ... wrapping modulo NREQ.
  - The first i with req_valid[i]=1 wins and gets req_ready[i]=1; all other req_ready bits are 0.
  - At most one grant per cycle.
- stall=1: req_ready = 0, mux_select = 0, last_grant unchanged.
- No valid request: req_ready = 0, mux_select = 0, last_grant unchanged.
- mux_select equals the granted requester's address in the grant cycle; otherwise 0.
- Grant side effects, on the clk edge ending the grant cycle N:
  - last_grant <= i.
  - resp_valid <= onehot(i).
  - resp_data <= selected word.
- Response latency: exactly 1 cycle; resp_valid is high for cycle N+1 only and is 0 in every cycle with no grant in the prior cycle.
- Selected word, in priority order:
  - (ZERO_R0 && addr==0) -> 0. This also applies when wr_en targets address 0.
  - else (BYPASS && wr_en && wr_addr==addr) -> wr_data.
  - else mux_data.
- Requesters must hold req_valid and req_addr stable until accepted. A requester dropping req_valid before grant is legal; no response is produced for it.
- Back-to-back: the same requester may be granted on consecutive cycles only if no other requester is valid.
- Fairness: with all NREQ continuously valid, each requester is granted once every NREQ cycles.
- busy = |req_valid & ~req_ready (includes the stall case).
- Reset mid-operation: an in-flight response (granted in the cycle before rst_n fell) is dropped, and resp_valid stays 0 until the first grant after rst_n rises.
- Widths: no arithmetic beyond the pointer wrap; the pointer is ceil(log2(NREQ)) bits and must wrap from NREQ-1 to 0, never reaching values >= NREQ.

Test Plan:
- Reset: hold rst_n=0 with req_valid=3'b111 -> req_ready=0, resp_valid=0, resp_data=0. Release rst_n; the first grant goes to requester 0.
- Single read: req_valid=3'b010, req_addr[1]=5, mux model returns 0x1234_5678 for select 5 -> req_ready=3'b010 and mux_select=5 that cycle; next cycle resp_valid=3'b010, resp_data=0x1234_5678.
- Round-robin: all three valid for 6 cycles, addresses 1/2/3 -> grants 0,1,2,0,1,2; responses follow one cycle later with matching data.
- $zero and bypass:
  - req addr 0 with mux returning 0xFFFF_FFFF -> resp_data=0.
  - req addr 7 with wr_en=1, wr_addr=7, wr_data=0xCAFE_0007 in the grant cycle -> resp_data=0xCAFE_0007, not the mux value.
- Stall: stall=1 for 3 cycles with requests valid -> req_ready=0, mux_select=0, no resp_valid, busy=1. On release, grant resumes from the pointer saved before the stall.
- Reset mid-op: grant requester 2 in cycle N, assert rst_n low mid-cycle N+1 -> resp_valid=0 immediately. After release, the next grant goes to requester 0.

Source files
------------

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
//
// Shares the single register-file read port among NREQ requesters. One
// requester is granted per cycle in round-robin order; its address drives the
// select of the combinational read mux. The selected word (after $zero and
// write-bypass rules) is registered and returned one cycle later with a
// one-hot response strobe.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   stall       pipeline stall, suppresses new grants
//   req_valid   per-requester read request            [NREQ]
//   req_addr    packed addresses, requester i at [i*AW +: AW]
//   req_ready   one-hot grant                         [NREQ]
//   mux_select  select input of the register-file read mux
//   mux_data    read mux output (combinational from mux_select)
//   wr_en       same-cycle register-file write strobe
//   wr_addr     write address
//   wr_data     write data
//   resp_valid  one-hot response strobe, one cycle    [NREQ]
//   resp_data   read data, valid with any resp_valid bit
//   busy        some request pending but not granted this cycle

module rf_read_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      mux_select,
  input  logic [DW-1:0]      mux_data,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic [NREQ-1:0]    resp_valid,
  output logic [DW-1:0]      resp_data,
  output logic               busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LastIdx = PW'(NREQ - 1);

  // Round-robin pointer and response registers
  logic [PW-1:0]   last_grant_q, last_grant_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;

  // Arbitration results
  logic            found;
  logic [PW-1:0]   grant_idx;
  logic            grant_valid;
  logic [NREQ-1:0] grant_onehot;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_word;

  // Per-requester address view of the packed bus
  logic [AW-1:0] req_addr_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_addr_unpack
    assign req_addr_arr[g] = req_addr[g*AW +: AW];
  end

  // Search starts one past the last winner and wraps modulo NREQ, so the
  // candidate index never reaches values >= NREQ.
  int unsigned   cand;
  logic [PW-1:0] cand_idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_grant_q) + k) % NREQ;
      cand_idx = PW'(cand);
      if (!found && req_valid[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // No grants during reset or stall
  assign grant_valid = rst_n && !stall && found;

  always_comb begin
    grant_onehot = '0;
    sel_addr     = '0;
    if (grant_valid) begin
      grant_onehot = NREQ'(1) << grant_idx;
      sel_addr     = req_addr_arr[grant_idx];
    end
  end

  // $zero wins over bypass, even when a write targets address 0
  always_comb begin
    sel_word = mux_data;
    if (ZERO_R0 && (sel_addr == '0)) begin
      sel_word = '0;
    end else if (BYPASS && wr_en && (wr_addr == sel_addr)) begin
      sel_word = wr_data;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (grant_valid) begin
      last_grant_d = grant_idx;
      resp_valid_d = grant_onehot;
      resp_data_d  = sel_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LastIdx;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready  = grant_onehot;
  assign mux_select = sel_addr;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = |(req_valid & ~grant_onehot);

endmodule

// File: tb/tb_rf_read_arbiter.sv
module tb_rf_read_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  logic               clk;
  logic               rst_n;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      mux_select;
  logic [DW-1:0]      mux_data;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic               busy;

  int n_checks;
  int n_fail;

  logic [DW-1:0] mem [32];

  rf_read_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .ZERO_R0 (1'b1),
    .BYPASS  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .mux_select (mux_select),
    .mux_data   (mux_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // Register-file read mux model
  assign mux_data = mem[mux_select];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = 32'h1111_0001;
    mem[2] = 32'h2222_0002;
    mem[3] = 32'h3333_0003;
    mem[5] = 32'h1234_5678;
    mem[7] = 32'h0BAD_0007;

    rst_n     = 1'b0;
    stall     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    req_valid = 3'b111;
    req_addr  = '0;
    set_addr(0, 5'd1);
    set_addr(1, 5'd2);
    set_addr(2, 5'd3);

    // Reset state
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    next_cycle();
    next_cycle();
    check("rst_ready_held", 32'(req_ready), 32'h0);

    // First grant after reset goes to requester 0
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant", 32'(req_ready), 32'h1);
    check("first_sel", 32'(mux_select), 32'd1);
    check("first_busy", 32'(busy), 32'h1);
    next_cycle();
    req_valid = 3'b000;
    @(negedge clk);
    check("first_resp_valid", 32'(resp_valid), 32'h1);
    check("first_resp_data", resp_data, 32'h1111_0001);
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_sel", 32'(mux_select), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    next_cycle();
    @(negedge clk);
    check("no_resp_after_idle", 32'(resp_valid), 32'h0);

    // Single read from requester 1 at address 5
    next_cycle();
    set_addr(1, 5'd5);
    req_valid = 3'b010;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h2);
    check("single_sel", 32'(mux_select), 32'd5);
    next_cycle();
    req_valid = 3'b000;
    set_addr(1, 5'd2);
    @(negedge clk);
    check("single_resp_valid", 32'(resp_valid), 32'h2);
    check("single_resp_data", resp_data, 32'h1234_5678);

    // $zero: requester 2 reads address 0, mux would return all ones
    next_cycle();
    set_addr(2, 5'd0);
    req_valid = 3'b100;
    @(negedge clk);
    check("zero_ready", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = 3'b000;
    set_addr(2, 5'd3);
    @(negedge clk);
    check("zero_resp_valid", 32'(resp_valid), 32'h4);
    check("zero_resp_data", resp_data, 32'h0);

    // Round-robin: pointer now at 2, so grants run 0,1,2,0,1,2
    next_cycle();
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      check("rr_sel", 32'(mux_select), 32'((k % 3) + 1));
      if (k > 0) begin
        check("rr_resp_valid", 32'(resp_valid), 32'(1 << ((k - 1) % 3)));
        check("rr_resp_data", resp_data, mem[((k - 1) % 3) + 1]);
      end
      next_cycle();
    end
    req_valid = 3'b000;
    @(negedge clk);
    check("rr_last_resp_valid", 32'(resp_valid), 32'h4);
    check("rr_last_resp_data", resp_data, 32'h3333_0003);

    // Bypass: requester 0 reads 7 while 7 is written the same cycle
    next_cycle();
    set_addr(0, 5'd7);
    req_valid = 3'b001;
    wr_en     = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 32'hCAFE_0007;
    @(negedge clk);
    check("byp_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 3'b000;
    wr_en     = 1'b0;
    @(negedge clk);
    check("byp_resp_data", resp_data, 32'hCAFE_0007);

    // Write to address 0 must not bypass over $zero
    next_cycle();
    set_addr(1, 5'd0);
    req_valid = 3'b010;
    wr_en     = 1'b1;
    wr_addr   = 5'd0;
    wr_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("zero_byp_ready", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 3'b000;
    wr_en     = 1'b0;
    set_addr(0, 5'd1);
    set_addr(1, 5'd2);
    @(negedge clk);
    check("zero_byp_resp_data", resp_data, 32'h0);

    // Stall: pointer at 1, so resume grants requester 2
    next_cycle();
    req_valid = 3'b111;
    stall     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready", 32'(req_ready), 32'h0);
      check("stall_sel", 32'(mux_select), 32'h0);
      check("stall_resp_valid", 32'(resp_valid), 32'h0);
      check("stall_busy", 32'(busy), 32'h1);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall_ready", 32'(req_ready), 32'h4);
    check("unstall_sel", 32'(mux_select), 32'd3);
    next_cycle();
    req_valid = 3'b000;
    @(negedge clk);
    check("unstall_resp_valid", 32'(resp_valid), 32'h4);
    check("unstall_resp_data", resp_data, 32'h3333_0003);

    // Same requester back-to-back when alone
    next_cycle();
    req_valid = 3'b001;
    @(negedge clk);
    check("b2b_ready0", 32'(req_ready), 32'h1);
    next_cycle();
    @(negedge clk);
    check("b2b_ready1", 32'(req_ready), 32'h1);
    check("b2b_resp_valid", 32'(resp_valid), 32'h1);
    next_cycle();
    req_valid = 3'b000;

    // Reset mid-op: grant requester 2, then reset during the response cycle
    next_cycle();
    req_valid = 3'b100;
    @(negedge clk);
    check("midrst_grant", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = 3'b000;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'h0);
    check("midrst_resp_data", resp_data, 32'h0);
    next_cycle();
    rst_n     = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    check("postrst_grant", 32'(req_ready), 32'h1);
    check("postrst_no_resp", 32'(resp_valid), 32'h0);
    next_cycle();
    req_valid = 3'b000;
    @(negedge clk);
    check("postrst_resp_valid", 32'(resp_valid), 32'h1);
    check("postrst_resp_data", resp_data, 32'h1111_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
